// File: rtl/pe_pkg.sv
// ============================================================================
// Module   : pe_pkg
// Purpose  : Shared FSM state encoding and config address map for pe_feeder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pe_pkg;

    // Frame sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Config register address map
    localparam logic [2:0] c_ADDR_W1   = 3'd0;
    localparam logic [2:0] c_ADDR_W2   = 3'd1;
    localparam logic [2:0] c_ADDR_W3   = 3'd2;
    localparam logic [2:0] c_ADDR_W4   = 3'd3;
    localparam logic [2:0] c_ADDR_W5   = 3'd4;
    localparam logic [2:0] c_ADDR_BIAS = 3'd5;

endpackage : pe_pkg

`default_nettype wire

// File: rtl/pe_feeder.sv
// ============================================================================
// Module   : pe_feeder
// Purpose  : Feeds a sample stream, weights and bias into an external PE
//            chain, flushes the chain at frame end and tags returning psums.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_feeder
    import pe_pkg::*;
#(
    parameter int DW   = 32,
    parameter int NTAP = 5,
    parameter int LAT  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  logic [DW-1:0] cfg_wdata,
    input  logic          start,
    input  logic [15:0]   frame_len,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic [DW-1:0] oX,
    output logic [DW-1:0] oW1,
    output logic [DW-1:0] oW2,
    output logic [DW-1:0] oW3,
    output logic [DW-1:0] oW4,
    output logic [DW-1:0] oW5,
    output logic [DW-1:0] oBias,
    input  logic [DW-1:0] pe_psum,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          busy,
    output logic          done,
    output logic          underrun
);

    // Idle counter saturates here; flush runs NTAP-1 cycles, drain LAT cycles
    localparam logic [7:0] c_IDLE_MAX   = 8'(NTAP);
    localparam logic [7:0] c_FLUSH_LAST = 8'(NTAP - 2);
    localparam logic [7:0] c_DRAIN_LAST = 8'(LAT - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_idle;
    logic [7:0]      r_fcnt;
    logic [7:0]      r_dcnt;
    logic [15:0]     r_len;
    logic [15:0]     r_cnt;
    logic [15:0]     w_cnt_inc;
    logic            r_underrun;
    logic [DW-1:0]   r_w [5];
    logic [DW-1:0]   r_bias;
    logic [LAT-1:0]  r_tag_v;
    logic [LAT-1:0]  r_tag_l;
    logic            w_tag;
    logic            w_tag_last;
    logic            w_start_ok;

    assign w_cnt_inc = r_cnt + 16'd1;

    assign oW1      = r_w[0];
    assign oW2      = r_w[1];
    assign oW3      = r_w[2];
    assign oW4      = r_w[3];
    assign oW5      = r_w[4];
    assign oBias    = r_bias;
    assign m_valid  = r_tag_v[LAT-1];
    assign m_last   = r_tag_l[LAT-1];
    assign m_data   = pe_psum;
    assign underrun = r_underrun;

    // Next-state decode and per-cycle chain drive / tag issue
    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        oX          = '0;
        w_tag       = 1'b0;
        w_tag_last  = 1'b0;
        w_start_ok  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && (frame_len != 16'd0) && (r_idle == c_IDLE_MAX)) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                s_ready = 1'b1;
                if (s_valid) begin
                    oX    = s_data;
                    w_tag = 1'b1;
                    if (w_cnt_inc == r_len) begin
                        w_state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                busy  = 1'b1;
                w_tag = 1'b1;
                if (r_fcnt == c_FLUSH_LAST) begin
                    w_tag_last  = 1'b1;
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (r_dcnt == c_DRAIN_LAST) begin
                    done        = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame counters, idle gating counter and sticky underrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idle     <= '0;
            r_fcnt     <= '0;
            r_dcnt     <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_underrun <= 1'b0;
        end else begin
            // oX is forced to 0 throughout IDLE, so every IDLE cycle counts
            if (r_state == IDLE) begin
                if (r_idle != c_IDLE_MAX) begin
                    r_idle <= r_idle + 8'd1;
                end
            end else begin
                r_idle <= '0;
            end

            if (w_start_ok) begin
                r_len      <= frame_len;
                r_cnt      <= '0;
                r_underrun <= 1'b0;
            end

            if (r_state == RUN) begin
                if (s_valid) begin
                    r_cnt <= w_cnt_inc;
                end else begin
                    r_underrun <= 1'b1;
                end
            end

            r_fcnt <= (r_state == FLUSH) ? r_fcnt + 8'd1 : 8'd0;
            r_dcnt <= (r_state == DRAIN) ? r_dcnt + 8'd1 : 8'd0;
        end
    end

    // Weight and bias registers, writable only while IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 5; i++) begin
                r_w[i] <= '0;
            end
            r_bias <= '0;
        end else if (cfg_we && (r_state == IDLE)) begin
            case (cfg_addr)
                c_ADDR_W1:   r_w[0] <= cfg_wdata;
                c_ADDR_W2:   r_w[1] <= cfg_wdata;
                c_ADDR_W3:   r_w[2] <= cfg_wdata;
                c_ADDR_W4:   r_w[3] <= cfg_wdata;
                c_ADDR_W5:   r_w[4] <= cfg_wdata;
                c_ADDR_BIAS: r_bias <= cfg_wdata;
                default: ;
            endcase
        end
    end

    // Tag pipeline aligning each issued tag with the chain's psum latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_v <= '0;
            r_tag_l <= '0;
        end else begin
            r_tag_v[0] <= w_tag;
            r_tag_l[0] <= w_tag_last;
            for (int i = 1; i < LAT; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_l[i] <= r_tag_l[i-1];
            end
        end
    end

endmodule : pe_feeder

`default_nettype wire

// File: tb/tb_pe_feeder.sv
// ============================================================================
// Module   : tb_pe_feeder
// Purpose  : Scoreboard bench for pe_feeder with a behavioural PE chain.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pe_feeder;

    localparam int DW   = 32;
    localparam int NTAP = 5;
    localparam int LAT  = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [2:0]    cfg_addr;
    logic [DW-1:0] cfg_wdata;
    logic          start;
    logic [15:0]   frame_len;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic [DW-1:0] oX, oW1, oW2, oW3, oW4, oW5, oBias;
    logic [DW-1:0] pe_psum;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy, done, underrun;

    pe_feeder #(.DW(DW), .NTAP(NTAP), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .start(start), .frame_len(frame_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .oX(oX), .oW1(oW1), .oW2(oW2), .oW3(oW3), .oW4(oW4), .oW5(oW5),
        .oBias(oBias), .pe_psum(pe_psum),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural PE chain (LAT = 1) ----------------
    logic [DW-1:0] wv [5];
    int            ch_hist [NTAP-1];

    always_comb begin
        wv[0] = oW1; wv[1] = oW2; wv[2] = oW3; wv[3] = oW4; wv[4] = oW5;
    end

    initial for (int k = 0; k < NTAP-1; k++) ch_hist[k] = 0;

    function automatic int chain_next();
        int acc;
        acc = int'($signed(oBias)) + int'($signed(wv[NTAP-1])) * int'($signed(oX));
        for (int k = 1; k < NTAP; k++)
            acc += int'($signed(wv[NTAP-1-k])) * ch_hist[k-1];
        return acc;
    endfunction

    always @(posedge clk) begin
        pe_psum    <= chain_next();
        ch_hist[0] <= int'($signed(oX));
        for (int k = 1; k < NTAP-1; k++) ch_hist[k] <= ch_hist[k-1];
    end

    // ---------------- scoreboard ----------------
    typedef struct { int data; bit last; } exp_t;
    exp_t sbq[$];
    exp_t mon_e;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   n_mv   = 0;
    int   n_done = 0;
    int   mw [5];
    int   mbias;
    int   ref34 [7] = '{5, 14, 26, 20, 14, 8, 3};

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pop one expectation for every result the DUT presents
    always @(negedge clk) begin
        if (rst === 1'b1 && m_valid === 1'b1) begin
            n_mv++;
            if (sbq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_m_valid: got data %0d with empty queue at %0t",
                         $signed(m_data), $time);
            end else begin
                mon_e = sbq.pop_front();
                chk("m_data", int'($signed(m_data)), mon_e.data);
                chk("m_last", int'(m_last), int'(mon_e.last));
            end
        end
        if (rst === 1'b1 && done === 1'b1) n_done++;
    end

    // Reference: y[j] = bias + sum_k w(NTAP-k) * x[j-k] over the oX sequence
    function automatic int exp_at(input int h[$], input int j);
        int acc;
        acc = mbias;
        for (int k = 0; k < NTAP; k++)
            if (j - k >= 0) acc += mw[NTAP-1-k] * h[j-k];
        return acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int a, input int v);
        cfg_we    = 1'b1;
        cfg_addr  = 3'(a);
        cfg_wdata = v;
        tick();
        cfg_we = 1'b0;
        if (a < 5) mw[a] = v;
        else if (a == 5) mbias = v;
        case (a)
            0: chk("cfg_w1", int'($signed(oW1)), mw[0]);
            1: chk("cfg_w2", int'($signed(oW2)), mw[1]);
            2: chk("cfg_w3", int'($signed(oW3)), mw[2]);
            3: chk("cfg_w4", int'($signed(oW4)), mw[3]);
            4: chk("cfg_w5", int'($signed(oW5)), mw[4]);
            5: chk("cfg_bias", int'($signed(oBias)), mbias);
            default: begin
                chk("cfg_bad_bias", int'($signed(oBias)), mbias);
                chk("cfg_bad_w1", int'($signed(oW1)), mw[0]);
            end
        endcase
    endtask

    // One frame: dir uses samples 1..len with constant reference results,
    // gap_j forces one s_valid=0 cycle, gap_pct adds random gaps.
    task automatic run_frame(input int len, input int gap_pct, input int gap_j,
                             input bit dir, input bit cfg_poke, input bit abort);
        int  h[$];
        int  cnt, j, d, mv0, done0, e;
        bit  v, gapped;
        mv0 = n_mv; done0 = n_done; cnt = 0; j = 0; gapped = 0;
        start = 1'b1; frame_len = 16'(len);
        tick();
        start = 1'b0;
        chk("busy_run", int'(busy), 1);
        chk("underrun_clr", int'(underrun), 0);
        while (cnt < len) begin
            if (j > 400) begin
                chk("run_bound", j, 0);
                break;
            end
            v = (j != gap_j) && (int'($urandom_range(99)) >= gap_pct);
            d = v ? (dir ? cnt + 1 : int'($urandom_range(100)) - 50) : 0;
            s_valid = v; s_data = d;
            if (cfg_poke && j == 0) begin
                cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 99;
            end
            #1;
            chk("s_ready_run", int'(s_ready), 1);
            chk("oX_run", int'($signed(oX)), d);
            h.push_back(d);
            if (v) begin
                e = dir ? ref34[j] + mbias : exp_at(h, j);
                sbq.push_back('{e, 1'b0});
            end else gapped = 1;
            tick();
            if (cfg_poke && j == 0) begin
                cfg_we = 1'b0;
                chk("cfg_lock", int'($signed(oW1)), mw[0]);
            end
            if (v) cnt++;
            j++;
        end
        s_valid = 1'b0; s_data = '0;
        for (int f = 0; f < NTAP-1; f++) begin
            if (abort && f == 1) begin
                rst = 1'b0;
                #1;
                chk("rst_oX", int'(oX), 0);
                chk("rst_s_ready", int'(s_ready), 0);
                chk("rst_m_valid", int'(m_valid), 0);
                chk("rst_m_last", int'(m_last), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_w1", int'(oW1), 0);
                sbq.delete();
                for (int i = 0; i < 5; i++) mw[i] = 0;
                mbias = 0;
                repeat (2) tick();
                rst = 1'b1;
                tick();
                chk("abort_no_done", n_done - done0, 0);
                chk("abort_busy", int'(busy), 0);
                return;
            end
            chk("s_ready_flush", int'(s_ready), 0);
            chk("oX_flush", int'(oX), 0);
            chk("busy_flush", int'(busy), 1);
            h.push_back(0);
            e = dir ? ref34[j] + mbias : exp_at(h, j);
            sbq.push_back('{e, f == NTAP-2});
            tick();
            j++;
        end
        chk("done_pulse", int'(done), 1);
        chk("busy_drain", int'(busy), 1);
        tick();
        chk("busy_idle", int'(busy), 0);
        chk("done_low", int'(done), 0);
        chk("n_results", n_mv - mv0, len + NTAP - 1);
        chk("n_done", n_done - done0, 1);
        chk("underrun", int'(underrun), int'(gapped));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        start = 1'b0; frame_len = '0; s_valid = 1'b0; s_data = '0;
        for (int i = 0; i < 5; i++) mw[i] = 0;
        mbias = 0;
        repeat (3) tick();
        chk("reset_oX", int'(oX), 0);
        chk("reset_s_ready", int'(s_ready), 0);
        chk("reset_m_valid", int'(m_valid), 0);
        chk("reset_m_last", int'(m_last), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_underrun", int'(underrun), 0);
        chk("reset_bias", int'(oBias), 0);
        rst = 1'b1;

        // Start too soon after reset release is ignored
        repeat (2) tick();
        start = 1'b1; frame_len = 16'd3;
        tick();
        start = 1'b0;
        chk("start_early_ignored", int'(busy), 0);

        // Zero-length start is ignored
        repeat (5) tick();
        start = 1'b1; frame_len = 16'd0;
        tick();
        start = 1'b0;
        chk("start_len0_ignored", int'(busy), 0);

        for (int i = 0; i < 5; i++) set_cfg(i, i + 1);
        set_cfg(5, 0);
        set_cfg(6, 77);
        set_cfg(7, 55);

        run_frame(3, 0, -1, 1'b1, 1'b0, 1'b0);      // contiguous frame
        set_cfg(5, 10);
        repeat (5) tick();
        run_frame(3, 0, -1, 1'b1, 1'b0, 1'b0);      // bias frame
        repeat (5) tick();
        run_frame(3, 0, 1, 1'b0, 1'b0, 1'b0);       // one-cycle gap
        repeat (5) tick();
        run_frame(4, 0, -1, 1'b0, 1'b1, 1'b0);      // cfg lockout during RUN
        set_cfg(0, 99);
        repeat (5) tick();
        run_frame(3, 0, -1, 1'b0, 1'b0, 1'b1);      // reset in FLUSH

        for (int i = 0; i < 5; i++) set_cfg(i, i + 1);
        set_cfg(5, 0);
        repeat (5) tick();
        run_frame(3, 0, -1, 1'b1, 1'b0, 1'b0);      // frame after abort

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 5; i++) set_cfg(i, int'($urandom_range(16)) - 8);
            set_cfg(5, int'($urandom_range(40)) - 20);
            repeat (5) tick();
            run_frame(int'($urandom_range(8, 1)), 20, -1, 1'b0, 1'b0, 1'b0);
        end

        repeat (3) tick();
        chk("sb_empty", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_pe_feeder

`default_nettype wire

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 SHALL have parameter DW, default 32: sample, weight and psum width, signed.
REQ-002 SHALL have parameter NTAP, default 5: number of taps in the PE chain.
REQ-003 SHALL have parameter LAT, default 1: cycles from oX drive to the matching chain psum.
REQ-004 SHALL have port clk  in  1: single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have ports cfg_we in 1, cfg_addr in 3, cfg_wdata in DW: config writes; addr 0..4 select w1..w5, addr 5 selects bias.
REQ-007 SHALL have ports start in 1 and frame_len in 16: frame launch and sample count.
REQ-008 SHALL have ports s_valid in 1, s_ready out 1, s_data in DW: input sample stream.
REQ-009 SHALL have ports oX out DW, oW1..oW5 out DW each, oBias out DW: drive chain iX, w1..w5 and iPsum.
REQ-010 SHALL have port pe_psum  in  DW: final psum returned from the chain.
REQ-011 SHALL have ports m_valid out 1, m_data out DW, m_last out 1: result stream, no backpressure.
REQ-012 SHALL have ports busy out 1, done out 1, underrun out 1: status, done pulse, sticky underrun flag.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, FLUSH, DRAIN.
REQ-014 SHALL accept cfg writes only in IDLE; writes in other states are ignored; addr 6..7 are ignored.
REQ-015 SHALL drive oW1..oW5 and oBias continuously from the weight and bias registers.
REQ-016 SHALL keep an idle counter, saturating at NTAP, that counts consecutive IDLE cycles with oX=0.
REQ-017 SHALL take IDLE->RUN on start only when frame_len!=0 and the idle counter equals NTAP; otherwise start is ignored.
REQ-018 SHALL latch frame_len, clear underrun and clear the sample counter on an accepted start.
REQ-019 SHALL, in RUN, hold s_ready=1; each cycle with s_valid drives oX=s_data and increments the sample counter.
REQ-020 SHALL, on a RUN cycle without s_valid, drive oX=0, issue no result tag, and set underrun; the chain still advances.
REQ-021 SHALL go RUN->FLUSH on the cycle the frame_len-th sample is accepted.
REQ-022 SHALL, in FLUSH, hold s_ready=0, drive oX=0 for exactly NTAP-1 cycles, and issue a valid tag each cycle.
REQ-023 SHALL go FLUSH->DRAIN after the last flush cycle, and DRAIN->IDLE after LAT cycles with done=1 for one cycle.
REQ-024 SHALL hold s_ready=0 and oX=0 outside RUN, and hold busy=1 in RUN, FLUSH and DRAIN.
REQ-025 SHALL delay each issued tag through a LAT-deep shift register; m_valid is the delayed tag and m_data=pe_psum, unregistered.
REQ-026 SHALL set m_last with m_valid for the final FLUSH tag, giving frame_len+NTAP-1 results per frame.
REQ-027 SHALL ignore start while busy.
REQ-028 SHALL compute no arithmetic of its own; the sample counter is 16-bit and compares for equality with the latched frame_len.

Reset
REQ-029 SHALL, on rst low, asynchronously enter IDLE and clear the weights, bias, counters, tags and underrun.
REQ-030 SHALL drive oX=0, s_ready=0, m_valid=0, m_last=0, busy=0 and done=0 during and after reset.
REQ-031 SHALL, on reset during a frame, abandon the frame with no done and no m_last; the idle counter restarts from 0.

Structure
REQ-032 SHALL take the FSM state encoding and the cfg address constants (W1..W5=0..4, BIAS=5) from a shared package pe_pkg.
REQ-033 SHALL be implemented as one module containing the LAT-deep tag pipeline inline; no sub-module is required.

Verification
REQ-034 SHALL cover a contiguous frame: w=1..5, bias=0, frame_len=3, samples 1,2,3 -> m_data 5,14,26,20,14,8,3 with m_last on 3, then done.
REQ-035 SHALL cover bias: bias=10, same frame -> each result is the REQ-034 value plus 10.
REQ-036 SHALL cover a gap: one s_valid=0 cycle mid-frame -> underrun=1, 7 m_valid pulses still, underrun cleared by the next start.
REQ-037 SHALL cover start gating: start 2 cycles after reset release -> ignored; start with frame_len=0 -> ignored; start after 5 idle cycles -> accepted.
REQ-038 SHALL cover config lockout: cfg_we to w1 during RUN -> oW1 unchanged; the same write in IDLE takes effect next cycle.
REQ-039 SHALL cover reset mid-frame: rst low in FLUSH -> all outputs 0 immediately, no done; a following frame runs correctly.
